// File: rtl/wb_regfile_if.sv
// Bundles the MEM/WB writeback inputs, the ID read ports and the debug/status outputs of wb_regfile.
// master: the pipeline side, which drives the writeback fields and the read addresses.
// slave:  the register file, which returns the read data, the writeback value and the commit status.
interface wb_regfile_if #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 32
);
  // MEM/WB writeback fields
  logic             RegWrite;
  logic             MemRead;
  logic [WIDTH-1:0] ALUResult;
  logic [WIDTH-1:0] memReadData;
  logic [4:0]       regWriteAddress;
  // read port addresses
  logic [4:0]       rsAddr;
  logic [4:0]       rtAddr;
  logic [4:0]       dbgAddr;
  // results
  logic [WIDTH-1:0] rsData;
  logic [WIDTH-1:0] rtData;
  logic [WIDTH-1:0] dbgData;
  logic [WIDTH-1:0] wbData;
  logic [CNTW-1:0]  wbCount;
  logic [4:0]       lastWbAddr;

  modport master (
    output RegWrite, MemRead, ALUResult, memReadData, regWriteAddress,
           rsAddr, rtAddr, dbgAddr,
    input  rsData, rtData, dbgData, wbData, wbCount, lastWbAddr
  );

  modport slave (
    input  RegWrite, MemRead, ALUResult, memReadData, regWriteAddress,
           rsAddr, rtAddr, dbgAddr,
    output rsData, rtData, dbgData, wbData, wbCount, lastWbAddr
  );
endinterface

// File: rtl/wb_regfile.sv
// Writeback stage register file: selects the writeback value, commits it to a MIPS GPR array,
// serves two combinational ID read ports with write-first bypass, and a registered debug port.
// Ports: clk, reset (sync, active-high), bus (wb_regfile_if.slave) carrying MEM/WB fields,
//        read addresses rsAddr/rtAddr/dbgAddr and outputs rsData/rtData/dbgData/wbData/wbCount/lastWbAddr.
module wb_regfile #(
  parameter int NREGS = 32,
  parameter int WIDTH = 32,
  parameter int CNTW  = 32
) (
  input  logic         clk,
  input  logic         reset,
  wb_regfile_if.slave  bus
);

  logic [WIDTH-1:0] mem [NREGS];
  logic [WIDTH-1:0] wb_sel;
  logic             commit;
  logic [WIDTH-1:0] dbg_q;
  logic [CNTW-1:0]  cnt_q;
  logic [4:0]       last_q;

  assign wb_sel = bus.MemRead ? bus.memReadData : bus.ALUResult;

  // Reset blocks the commit so a write arriving on a reset edge is dropped entirely.
  assign commit = bus.RegWrite & (bus.regWriteAddress != 5'd0) & ~reset;

  // Array contents only; r0 and out-of-range addresses read as zero.
  function automatic logic [WIDTH-1:0] stored(input logic [4:0] a);
    if (a == 5'd0 || int'(a) >= NREGS) return '0;
    return mem[a];
  endfunction

  // Write-first bypass so ID sees the value being committed on this edge.
  function automatic logic [WIDTH-1:0] port_read(input logic [4:0] a);
    if (a == 5'd0) return '0;
    if (commit && a == bus.regWriteAddress) return wb_sel;
    return stored(a);
  endfunction

  assign bus.wbData     = wb_sel;
  assign bus.rsData     = port_read(bus.rsAddr);
  assign bus.rtData     = port_read(bus.rtAddr);
  assign bus.dbgData    = dbg_q;
  assign bus.wbCount    = cnt_q;
  assign bus.lastWbAddr = last_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
      dbg_q  <= '0;
      cnt_q  <= '0;
      last_q <= '0;
    end else begin
      // Debug read samples the array before this edge's write lands.
      dbg_q <= stored(bus.dbgAddr);
      if (commit) begin
        mem[bus.regWriteAddress] <= wb_sel;
        cnt_q  <= cnt_q + 1'b1;
        last_q <= bus.regWriteAddress;
      end
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;
  localparam int CNTW = 8;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  wb_regfile_if #(.WIDTH(32), .CNTW(CNTW)) bus ();

  wb_regfile #(.NREGS(32), .WIDTH(32), .CNTW(CNTW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // reference state
  logic [31:0]     model [32];
  logic [CNTW-1:0] model_cnt;
  logic [4:0]      model_last;
  logic [31:0]     dbg_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rd(input logic [4:0] a, input logic cm, input logic [31:0] sel);
    if (a == 5'd0) return 32'h0;
    if (cm && a == bus.regWriteAddress) return sel;
    return model[a];
  endfunction

  // One clock: check combinational outputs, queue the expected debug data,
  // advance the model at the edge, then pop and check the registered outputs.
  task automatic step();
    logic [31:0] sel;
    logic        cm;
    #1;
    sel = bus.MemRead ? bus.memReadData : bus.ALUResult;
    cm  = bus.RegWrite && (bus.regWriteAddress != 5'd0) && !reset;
    if (!$isunknown(sel)) check("wbData", bus.wbData, sel);
    check("rsData", bus.rsData, rd(bus.rsAddr, cm, sel));
    check("rtData", bus.rtData, rd(bus.rtAddr, cm, sel));
    dbg_q.push_back((reset || bus.dbgAddr == 5'd0) ? 32'h0 : model[bus.dbgAddr]);
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
      model_cnt  = '0;
      model_last = '0;
    end else if (cm) begin
      model[bus.regWriteAddress] = sel;
      model_cnt  = model_cnt + 1'b1;
      model_last = bus.regWriteAddress;
    end
    #1;
    if (dbg_q.size() == 0) check("dbg_queue", 32'h0, 32'h1);
    else check("dbgData", bus.dbgData, dbg_q.pop_front());
    check("wbCount", 32'(bus.wbCount), 32'(model_cnt));
    check("lastWbAddr", 32'(bus.lastWbAddr), 32'(model_last));
  endtask

  task automatic wr(input logic [4:0] a, input logic mr, input logic [31:0] alu, input logic [31:0] md);
    bus.RegWrite        = 1'b1;
    bus.MemRead         = mr;
    bus.regWriteAddress = a;
    bus.ALUResult       = alu;
    bus.memReadData     = md;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    model_cnt  = '0;
    model_last = '0;
    reset = 1'b1;
    bus.RegWrite = 1'b0; bus.MemRead = 1'b0;
    bus.ALUResult = '0; bus.memReadData = '0; bus.regWriteAddress = '0;
    bus.rsAddr = '0; bus.rtAddr = '0; bus.dbgAddr = '0;

    // 1: reset two cycles, then sweep debug port
    step(); step();
    reset = 1'b0;
    for (int i = 1; i < 32; i++) begin
      bus.dbgAddr = 5'(i);
      step();
    end
    check("rst_wbCount", 32'(bus.wbCount), 32'h0);
    check("rst_lastWbAddr", 32'(bus.lastWbAddr), 32'h0);

    // 2: ALU writeback with same-cycle bypass on port A
    wr(5'd5, 1'b0, 32'h0000_1234, 32'h0);
    bus.rsAddr = 5'd5;
    bus.dbgAddr = 5'd5;
    #1 check("t2_bypass_rs", bus.rsData, 32'h0000_1234);
    step();
    bus.RegWrite = 1'b0;
    step();
    check("t2_dbg", bus.dbgData, 32'h0000_1234);
    check("t2_wbCount", 32'(bus.wbCount), 32'h1);
    check("t2_last", 32'(bus.lastWbAddr), 32'h5);

    // 3: load writeback, both ports bypass the same register
    wr(5'd7, 1'b1, 32'h1, 32'hDEAD_BEEF);
    bus.rsAddr = 5'd7; bus.rtAddr = 5'd7; bus.dbgAddr = 5'd7;
    #1 check("t3_rs", bus.rsData, 32'hDEAD_BEEF);
    check("t3_rt", bus.rtData, 32'hDEAD_BEEF);
    step();
    check("t3_dbg_old", bus.dbgData, 32'h0);
    bus.RegWrite = 1'b0;
    step();
    check("t3_dbg_new", bus.dbgData, 32'hDEAD_BEEF);

    // 4: write to r0 is discarded
    wr(5'd0, 1'b0, 32'hFFFF_FFFF, 32'h0);
    bus.rsAddr = 5'd0; bus.dbgAddr = 5'd0;
    #1 check("t4_rs0", bus.rsData, 32'h0);
    step();
    check("t4_wbCount", 32'(bus.wbCount), 32'h2);
    bus.RegWrite = 1'b0;
    step();
    check("t4_dbg0", bus.dbgData, 32'h0);

    // 5: RegWrite=0 leaves state alone, also with X on select/data
    wr(5'd9, 1'b0, 32'hA5A5_A5A5, 32'h0);
    step();
    bus.RegWrite = 1'b0; bus.ALUResult = 32'h0; bus.rsAddr = 5'd9; bus.dbgAddr = 5'd9;
    step();
    bus.MemRead = 1'bx; bus.ALUResult = 'x; bus.memReadData = 'x;
    step();
    check("t5_dbg9", bus.dbgData, 32'hA5A5_A5A5);
    check("t5_rs9", bus.rsData, 32'hA5A5_A5A5);
    check("t5_wbCount", 32'(bus.wbCount), 32'h3);
    bus.MemRead = 1'b0; bus.ALUResult = 32'h0; bus.memReadData = 32'h0;

    // 6a: counter wrap, with random read traffic along the way
    while (model_cnt != {CNTW{1'b1}}) begin
      wr(5'($urandom_range(1, 31)), 1'($urandom_range(0, 1)), $urandom, $urandom);
      bus.rsAddr = 5'($urandom_range(0, 31));
      bus.rtAddr = 5'($urandom_range(0, 31));
      bus.dbgAddr = 5'($urandom_range(0, 31));
      step();
    end
    check("t6_cnt_max", 32'(bus.wbCount), 32'(2**CNTW - 1));
    wr(5'd12, 1'b0, 32'h0C0C_0C0C, 32'h0);
    step();
    check("t6_cnt_wrap", 32'(bus.wbCount), 32'h0);
    check("t6_last", 32'(bus.lastWbAddr), 32'hC);

    // 6b: reset on the same edge as a write wins
    wr(5'd3, 1'b0, 32'h55, 32'h0);
    bus.rsAddr = 5'd12;
    reset = 1'b1;
    #1 check("t6_rst_nobypass", bus.rsData, 32'h0C0C_0C0C);
    step();
    reset = 1'b0;
    bus.RegWrite = 1'b0; bus.dbgAddr = 5'd3; bus.rsAddr = 5'd3;
    step();
    check("t6_r3", bus.dbgData, 32'h0);
    check("t6_rs3", bus.rsData, 32'h0);
    check("t6_cnt_rst", 32'(bus.wbCount), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
Writeback-side consumer of the MEM/WB pipeline register outputs.
- Selects the writeback value and commits it to a 32x32 MIPS general-purpose register file.
- Serves the ID stage's two source-operand read ports with same-cycle write-to-read bypass.
- Exposes a debug read port and a committed-writeback counter for the bench and the top level.

Parameters:
NREGS, 32, number of architectural registers (address width fixed at 5)
WIDTH, 32, data width of registers, writeback data and read ports
CNTW, 32, width of the writeback commit counter

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
RegWrite  input  1  writeback enable from MEM/WB
MemRead  input  1  1 = write memReadData, 0 = write ALUResult
ALUResult  input  WIDTH  ALU result from MEM/WB
memReadData  input  WIDTH  load data from MEM/WB
regWriteAddress  input  5  destination register from MEM/WB
rsAddr  input  5  ID read port A address
rtAddr  input  5  ID read port B address
dbgAddr  input  5  debug read port address
rsData  output  WIDTH  read port A data (combinational)
rtData  output  WIDTH  read port B data (combinational)
dbgData  output  WIDTH  debug read data (registered)
wbData  output  WIDTH  selected writeback value (combinational)
wbCount  output  CNTW  number of committed writebacks
lastWbAddr  output  5  destination of most recent committed write

Behaviour:
- Reset (synchronous, active-high, clk):
  - On a rising edge with reset=1, all registers 1..31 are cleared to 0.
  - dbgData, wbCount and lastWbAddr are cleared to 0.
  - Writes are ignored in that cycle.
  - A reset asserted on the same edge as a valid write wins; the write is lost and wbCount stays 0.
- Writeback select: wbData = MemRead ? memReadData : ALUResult. Purely combinational; valid even when RegWrite=0.
- Commit condition: commit = RegWrite & (regWriteAddress != 0) & ~reset.
  - On commit, the addressed register gets wbData at the rising edge.
  - On commit, wbCount increments by 1, wrapping from 2^CNTW-1 to 0.
  - On commit, lastWbAddr gets regWriteAddress.
  - Writes to register 0 are discarded and do not count.
- Register 0: always reads 0 on every port, regardless of any write attempt.
- Read ports A/B (combinational, zero added latency):
  - If addr == 0, output is 0.
  - Else, if commit=1 and addr == regWriteAddress, output is wbData (write-first bypass, so the ID stage sees the value being written back this cycle).
  - Else, output is the stored register.
  - The bypass applies independently to each port; both ports may hit the same bypass simultaneously.
  - While reset=1 the bypass is disabled and stored values are returned. This is the pre-clear contents during the reset cycle, and 0 afterwards.
- Debug port: dbgData is registered with 1-cycle latency and reads the stored array value (no bypass).
  - Reading the register written on the same edge returns the old value.
  - The new value is visible one cycle later.
- No read side effects. RegWrite=0 leaves all state unchanged, including wbCount.
- X on MemRead or data inputs while RegWrite=0 must not corrupt state.

Test Plan:
1. Assert reset 2 cycles, then read r1..r31 via dbg -> all dbgData=0; wbCount=0; lastWbAddr=0.
2. RegWrite=1, MemRead=0, ALUResult=0x0000_1234, addr=5, rsAddr=5 in the same cycle.
   - Required: rsData=0x1234 combinationally before the edge.
   - Required: dbgAddr=5 gives dbgData=0x1234 two cycles later.
   - Required: wbCount=1, lastWbAddr=5.
3. RegWrite=1, MemRead=1, memReadData=0xDEAD_BEEF, ALUResult=0x1, addr=7, rsAddr=rtAddr=7.
   - Required: rsData=rtData=0xDEADBEEF.
   - Required: r7 holds 0xDEADBEEF after the edge.
4. RegWrite=1, addr=0, ALUResult=0xFFFF_FFFF, rsAddr=0 -> rsData=0; r0 stays 0; wbCount unchanged.
5. Write r9=0xA5A5_A5A5. Next cycle, RegWrite=0 with addr=9 and ALUResult=0x0 -> r9 remains 0xA5A5A5A5; wbCount unchanged.
6. Preload wbCount to 0xFFFF_FFFF via back-to-back commits (or a forced value), then commit once -> wbCount=0. Separately, assert reset on the same edge as a write to r3=0x55 -> r3=0 and wbCount=0.
